// File: rtl/y_exec_stage.sv
// y_exec_stage: registered execute stage between operand fetch and writeback.
// Performs AND/OR/ADD/SUB/SLT on two signed operands and delivers the result
// with carry, signed-overflow and zero flags through a head register backed
// by a single skid entry, so downstream backpressure never loses or repeats
// a result. in_ready is a pure register output (no path from out_ready).
module y_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One buffered result bundle (head or skid entry).
  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  localparam res_t RES_ZERO = '{z: {WIDTH{1'b0}}, cout: 1'b0, ovf: 1'b0, zero: 1'b0};

  // Combinational ALU. SUB is formed as a + ~b + 1 so its carry reads as
  // "no borrow"; SLT reuses the subtraction sign corrected by its overflow.
  // The zero flag is taken from the freshly computed result.
  function automatic res_t alu_f(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [2:0]       op);
    res_t         r;
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           add_ovf;
    logic           sub_ovf;
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
    r = RES_ZERO;
    case (op)
      OP_AND: r.z = a & b;
      OP_OR:  r.z = a | b;
      OP_ADD: begin
        r.z    = add_w[WIDTH-1:0];
        r.cout = add_w[WIDTH];
        r.ovf  = add_ovf;
      end
      OP_SUB: begin
        r.z    = sub_w[WIDTH-1:0];
        r.cout = sub_w[WIDTH];
        r.ovf  = sub_ovf;
      end
      OP_SLT: r.z = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
      default: r.z = {WIDTH{1'b0}};
    endcase
    r.zero = (r.z == {WIDTH{1'b0}});
    return r;
  endfunction

  res_t head_r;
  res_t skid_r;
  logic head_valid_r;
  logic skid_valid_r;
  logic in_ready_r;

  res_t alu_s;
  res_t head_nx_s;
  res_t skid_nx_s;
  logic head_valid_nx_s;
  logic skid_valid_nx_s;
  logic push_s;
  logic pop_s;
  logic head_free_s;

  assign alu_s       = alu_f(in_a, in_b, in_op);
  assign push_s      = in_valid && in_ready_r;
  assign pop_s       = head_valid_r && out_ready;
  assign head_free_s = !head_valid_r || pop_s;

  // Next-state of head/skid: a free head refills from skid first, then from
  // the incoming op; a held head diverts the incoming op into the skid.
  always_comb begin
    head_nx_s       = head_r;
    head_valid_nx_s = head_valid_r;
    skid_nx_s       = skid_r;
    skid_valid_nx_s = skid_valid_r;
    if (head_free_s) begin
      if (skid_valid_r) begin
        head_nx_s       = skid_r;
        head_valid_nx_s = 1'b1;
        skid_valid_nx_s = 1'b0;
      end else if (push_s) begin
        head_nx_s       = alu_s;
        head_valid_nx_s = 1'b1;
      end else begin
        head_valid_nx_s = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_nx_s       = alu_s;
        skid_valid_nx_s = 1'b1;
      end else begin
        skid_valid_nx_s = skid_valid_r;
      end
    end
  end

  // State registers; in_ready is registered as "skid will be empty".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r       <= RES_ZERO;
      skid_r       <= RES_ZERO;
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      head_r       <= head_nx_s;
      skid_r       <= skid_nx_s;
      head_valid_r <= head_valid_nx_s;
      skid_valid_r <= skid_valid_nx_s;
      in_ready_r   <= !skid_valid_nx_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = head_valid_r;
  assign out_z     = head_r.z;
  assign out_cout  = head_r.cout;
  assign out_ovf   = head_r.ovf;
  assign out_zero  = head_r.zero;

endmodule

// File: tb/tb_y_exec_stage.sv
// Self-checking bench for y_exec_stage: directed corners plus randomized
// streaming/stall traffic checked against an arithmetic reference model and
// an in-order queue of expected results.
module tb_y_exec_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] z;
    logic        c;
    logic        o;
    logic        zr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped[$];

  y_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    e.z = 32'h0; e.c = 1'b0; e.o = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    sr = 64'sd0;
    case (op)
      3'b000: e.z = a & b;
      3'b001: e.z = a | b;
      3'b010: begin
        sr  = sa + sb;
        e.z = a + b;
        e.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b110: begin
        sr  = sa - sb;
        e.z = a - b;
        e.c = (ua >= ub);
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b111: e.z = (sa < sb) ? 32'd1 : 32'd0;
      default: e.z = 32'h0;
    endcase
    e.zr = (e.z == 32'h0);
    return e;
  endfunction

  // One clock: check outputs at negedge against the model queue, then apply
  // the transfers that happen at the following rising edge.
  task automatic tick();
    bit   push;
    bit   pop;
    exp_t pe;
    @(negedge clk);
    chk("out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
    chk("in_ready", {31'h0, in_ready}, {31'h0, (q.size() < 2)});
    if (q.size() != 0) begin
      chk("out_z", out_z, q[0].z);
      chk("out_cout", {31'h0, out_cout}, {31'h0, q[0].c});
      chk("out_ovf", {31'h0, out_ovf}, {31'h0, q[0].o});
      chk("out_zero", {31'h0, out_zero}, {31'h0, q[0].zr});
    end
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() != 0);
    pe   = model(in_a, in_b, in_op);
    @(posedge clk);
    #1;
    if (pop) begin
      popped.push_back(q[0].z);
      void'(q.pop_front());
    end
    if (push) q.push_back(pe);
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ez, input logic ec,
                          input logic eo, input logic ezr);
    in_valid = 1'b1; out_ready = 1'b1;
    in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    chk({tag, "_z"}, out_z, ez);
    chk({tag, "_cout"}, {31'h0, out_cout}, {31'h0, ec});
    chk({tag, "_ovf"}, {31'h0, out_ovf}, {31'h0, eo});
    chk({tag, "_zero"}, {31'h0, out_zero}, {31'h0, ezr});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_inputs();
    in_a  = rnd_operand();
    in_b  = ($urandom_range(0, 9) == 0) ? in_a : rnd_operand();
    in_op = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 32'h0; in_b = 32'h0; in_op = 3'b000;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_z", out_z, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Mid-stream reset with two buffered results.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b010;
    in_a = 32'd10; in_b = 32'd1; tick();
    in_a = 32'd20; in_b = 32'd2; tick();
    in_valid = 1'b0;
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_out_z", out_z, 32'h0);
    chk("mid_rst_flags", {29'h0, out_cout, out_ovf, out_zero}, 32'h0);
    q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'b010; in_a = 32'd3; in_b = 32'd4;
    tick();
    in_valid = 1'b0;
    chk("post_rst_add", out_z, 32'd7);
    tick();

    // Arithmetic / logic corners.
    directed("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("add_carry", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", 3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_eq", 3'b110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b1);
    directed("sub_borrow", 3'b110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("slt_m1_1", 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    directed("slt_1_m1", 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    directed("slt_min_max", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    directed("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    directed("or", 3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    directed("rsvd", 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: two accepted, third waits, all drain in order.
    popped.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b010;
    in_a = 32'd1; in_b = 32'd1; tick();
    in_a = 32'd2; in_b = 32'd2; tick();
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    in_a = 32'd3; in_b = 32'd3; tick();
    chk("bp_hold_z", out_z, 32'd2);
    out_ready = 1'b1; tick();
    chk("bp_ready_back", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0; tick(); tick();
    chk("bp_count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      chk("bp_0", popped[0], 32'd2);
      chk("bp_1", popped[1], 32'd4);
      chk("bp_2", popped[2], 32'd6);
    end

    // Streaming: one op per cycle, in_ready must stay high.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rnd_inputs();
      tick();
    end
    drain();

    // Random stall: random valid/ready with inputs changing every cycle.
    popped.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd_inputs();
      tick();
    end
    drain();
    chk("final_empty", {31'h0, out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/y_exec_stage.md
# y_exec_stage

Registered execute stage that directly consumes decoded operands and drives the 32-bit add/subtract datapath result toward writeback. It accepts one operation per cycle (AND, OR, ADD, SUB, SLT) over a valid/ready handshake. It computes result, carry, signed-overflow and zero flags, and buffers them in a two-entry output skid so that backpressure never drops or duplicates a result. It sits between operand fetch (register read) and writeback in the CPU datapath.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  stage can accept; registered
- in_a  input  WIDTH  operand A, signed
- in_b  input  WIDTH  operand B, signed
- in_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others reserved
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts
- out_z  output  WIDTH  result
- out_cout  output  1  carry out of MSB (ADD/SUB only)
- out_ovf  output  1  signed overflow (ADD/SUB only)
- out_zero  output  1  out_z == 0

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready at a rising edge.
- Storage: output register (head) plus one skid register. Results leave in acceptance order.
- Arithmetic (all mod 2^WIDTH):
  - ADD: z = a+b. cout = carry out of bit WIDTH-1. ovf = (a[msb]==b[msb]) && (z[msb]!=a[msb]).
  - SUB: z = a + ~b + 1. cout = carry of that sum (1 means no borrow). ovf = (a[msb]!=b[msb]) && (z[msb]!=a[msb]).
  - SLT: z = 1 if a<b signed, else 0. Computed as sub_result[msb] XOR sub_ovf. cout = ovf = 0.
  - AND/OR: bitwise. cout = ovf = 0.
  - Reserved op: z = 0, cout = ovf = 0, zero = 1. Not an error.
- out_zero is computed from the result before registering, not from out_z after.
- Per-edge buffer update:
  - Head empty or head popped: head loads skid if skid is full, else the incoming op if accepted.
  - Head held and an op is accepted: the op goes to skid.
  - Skid loads only while the head is held.
- in_ready next = !(skid full after this edge). The skid is never overwritten.

## Timing
- Latency: an op accepted at edge N appears on out_* immediately after edge N.
- Throughput: 1 op/cycle while out_ready stays high. in_ready stays 1 in that mode.
- Backpressure: with out_ready low, two ops are accepted. in_ready falls after the second edge. The third op waits.
- When out_ready rises with skid full: the head pops and the skid moves to the head at the same edge. in_ready is 1 after that edge. No new op is accepted on that edge, because in_ready was 0 during it.
- Simultaneous push and pop, skid empty: the new op replaces the head. out_valid stays 1 with no bubble.
- Pop with nothing incoming and skid empty: out_valid is 0 after the edge.
- Outputs are stable while out_valid && !out_ready. Changing inputs must not alter held results.
- Reset: on resetn low, asynchronously out_valid=0, out_z=0, out_cout=0, out_ovf=0, out_zero=0, skid empty, in_ready=1. Reset mid-operation discards both entries. The first acceptance is possible at the first edge after resetn deasserts.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.

## Test plan
- Reset: assert resetn=0 mid-stream with two buffered results -> out_valid=0, in_ready=1, out_z=0 immediately. After release, ADD 3+4 -> out_z=7 one edge later.
- Arithmetic corners (out_ready=1):
  - ADD 0x7FFFFFFF+1 -> z=0x80000000, ovf=1, cout=0.
  - ADD 0xFFFFFFFF+1 -> z=0, cout=1, ovf=0, zero=1.
  - SUB 0x80000000-1 -> z=0x7FFFFFFF, ovf=1, cout=1.
  - SUB 5-5 -> zero=1, cout=1.
- SLT/logic:
  - SLT -1,1 -> z=1.
  - SLT 1,-1 -> z=0.
  - SLT 0x80000000,0x7FFFFFFF -> z=1.
  - AND 0xF0F0,0xFF00 -> 0xF000.
  - OR -> 0xFFF0.
  - op=011 -> z=0, zero=1.
- Backpressure: out_ready=0 and push ADD 1+1, 2+2, 3+3 -> in_ready=0 after the second edge. Then out_ready=1 -> results 2, 4, 6 in order, none lost or duplicated.
- Streaming: 100 random ops with in_valid=out_ready=1 -> one result per cycle, one-cycle latency, each matches the reference model; in_ready never 0.
- Random stall: random in_valid/out_ready for 10,000 cycles -> output sequence equals the input sequence through the model, and held outputs are stable while stalled.
